// File: rtl/cayde_pkg.sv
// Shared definitions for the cayde instruction-memory loader: frame start
// byte, word/lane geometry and the loader state enum.
// Optional checksum support is selected with CAYDE_LOADER_CSUM_EN.
package cayde_pkg;

  localparam logic [7:0] CAYDE_MAGIC = 8'hCA;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned WORD_W = BYTE_W * LANES;

  localparam logic [LANE_W-1:0] LAST_LANE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
`ifdef CAYDE_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_FIN
  } loader_state_t;

endpackage

// File: rtl/cayde_byte_packer.sv
// Assembles four little-endian bytes into a 32-bit word. The word is
// presented combinationally on the cycle the lane-3 byte arrives, so the
// caller can register it together with the write strobe.
module cayde_byte_packer
  import cayde_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [LANE_W-1:0] lane_q;
  logic [23:0]       low_q;

  // Lane counter and storage for the three lower byte lanes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
      low_q  <= '0;
    end else if (clear) begin
      lane_q <= '0;
    end else if (byte_valid) begin
      lane_q <= lane_q + 1'b1;
      case (lane_q)
        2'd0:    low_q[7:0]   <= byte_in;
        2'd1:    low_q[15:8]  <= byte_in;
        2'd2:    low_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  // Completed word: lane-3 byte bypasses storage
  always_comb begin
    word_valid = byte_valid && (lane_q == LAST_LANE);
    word       = {byte_in, low_q};
  end

endmodule

// File: rtl/cayde_imem_loader.sv
// Framed byte-stream loader for the cayde instruction memory. Accepts
// MAGIC, CNT, 4*(CNT+1) data bytes and writes packed words into memory
// while holding the core in reset.
// Define CAYDE_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module cayde_imem_loader
  import cayde_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter logic [7:0]  MAGIC  = CAYDE_MAGIC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  loader_state_t state_q, state_d;

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             fail_q;

  logic        accept;
  logic        oversize;
  logic        last_word;
  logic        set_hold;
  logic        set_fail;
  logic        latch_cnt;
  logic        pk_valid;
  logic        word_valid;
  logic        wr_en;
  logic        done_d;
  logic        error_d;
  logic [31:0] pk_word;

`ifdef CAYDE_LOADER_CSUM_EN
  logic [7:0] csum_q;
  logic       csum_ok;
  assign csum_ok = (in_data == csum_q);
`endif

  assign accept    = in_valid & in_ready;
  assign oversize  = 32'(in_data) >= (32'd1 << IDX_W);
  assign last_word = (idx_q == cnt_q);

  cayde_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (latch_cnt),
    .byte_valid (pk_valid),
    .byte_in    (in_data),
    .word_valid (word_valid),
    .word       (pk_word)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    set_hold  = 1'b0;
    set_fail  = 1'b0;
    latch_cnt = 1'b0;
    pk_valid  = 1'b0;
    wr_en     = 1'b0;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && (in_data == MAGIC)) begin
          set_hold = 1'b1;
          state_d  = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (accept) begin
          if (oversize) begin
            set_fail = 1'b1;
            state_d  = ST_FIN;
          end else begin
            latch_cnt = 1'b1;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        pk_valid = accept;
        if (word_valid) begin
          wr_en = 1'b1;
          if (last_word) begin
`ifdef CAYDE_LOADER_CSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_FIN;
`endif
          end
        end
      end
`ifdef CAYDE_LOADER_CSUM_EN
      ST_CSUM: begin
        if (accept) begin
          set_fail = !csum_ok;
          state_d  = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        in_ready = 1'b0;
        done_d   = !fail_q;
        error_d  = fail_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: word count, word index and failure flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      if (latch_cnt) begin
        cnt_q <= IDX_W'(in_data);
        idx_q <= '0;
      end else if (wr_en) begin
        idx_q <= idx_q + 1'b1;
      end
      if (set_hold)      fail_q <= 1'b0;
      else if (set_fail) fail_q <= 1'b1;
    end
  end

`ifdef CAYDE_LOADER_CSUM_EN
  // Running XOR over data bytes only
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           csum_q <= '0;
    else if (latch_cnt) csum_q <= '0;
    else if (pk_valid)  csum_q <= csum_q ^ in_data;
  end
`endif

  // Registered memory write port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b0;
    end else begin
      mem_we <= wr_en;
      if (wr_en) begin
        mem_addr  <= {idx_q, 2'b00};
        mem_wdata <= pk_word;
      end
      done  <= done_d;
      error <= error_d;
      // hold drops as the done/error pulse ends, unless a new frame starts
      if (set_hold)           core_hold <= 1'b1;
      else if (done || error) core_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cayde_imem_loader.sv
module tb_cayde_imem_loader;

  localparam int unsigned ADDR_W = 9;
  localparam logic [7:0]  MAGIC  = 8'hCA;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              error;

  cayde_imem_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Observed activity, sampled mid-cycle
  logic [ADDR_W+31:0] got_wr[$];
  int unsigned done_cnt = 0, err_cnt = 0, hold_viol = 0, overlap_viol = 0;

  always @(negedge clk) begin
    if (mem_we) got_wr.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
    if (error) err_cnt++;
    if ((mem_we || done || error) && !core_hold) hold_viol++;
    if (done && mem_we) overlap_viol++;
  end

  // Reference model: payload bytes -> expected {addr, word} writes
  logic [7:0]         payload[$];
  logic [ADDR_W+31:0] exp_wr[$];

  function automatic void fill_payload(input int unsigned words, input bit ramp);
    payload.delete();
    for (int unsigned i = 0; i < 4 * words; i++)
      payload.push_back(ramp ? 8'(i) : 8'($urandom));
  endfunction

  function automatic void add_expected();
    for (int unsigned w = 0; w < payload.size() / 4; w++) begin
      logic [31:0] word;
      word = 32'(payload[4*w]) + (32'(payload[4*w+1]) << 8) +
             (32'(payload[4*w+2]) << 16) + (32'(payload[4*w+3]) << 24);
      exp_wr.push_back({ADDR_W'(4 * w), word});
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
    int unsigned tries;
    repeat ($urandom_range(gap_max, 0)) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tries = 0;
    while (in_ready !== 1'b1 && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) begin
      n_tests++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] cnt, input int unsigned gap_max);
    logic [7:0] x;
    x = '0;
    send_byte(MAGIC, gap_max);
    send_byte(cnt, gap_max);
    foreach (payload[i]) begin
      send_byte(payload[i], gap_max);
      x ^= payload[i];
    end
`ifdef CAYDE_LOADER_CSUM_EN
    send_byte(x, gap_max);
`endif
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result();
    int unsigned start, budget;
    start = done_cnt + err_cnt;
    budget = 0;
    while (done_cnt + err_cnt == start && budget < 200) begin
      @(negedge clk); #1;
      budget++;
    end
    if (budget >= 200) begin
      n_tests++; n_fail++;
      $display("FAIL result_timeout: no done/error pulse within 200 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error} !==
        {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b, required 1 0 0 0 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int unsigned w0, d0, e0;
    w0 = got_wr.size(); d0 = done_cnt; e0 = err_cnt;
    payload = '{8'h78, 8'h56, 8'h34, 8'h12};
    exp_wr.delete();
    exp_wr.push_back({ADDR_W'(0), 32'h12345678});
    send_byte(MAGIC, 0);
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (core_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold_rise: core_hold=%b, required 1", core_hold);
    end
    send_byte(8'h00, 0);
    foreach (payload[i]) send_byte(payload[i], 0);
`ifdef CAYDE_LOADER_CSUM_EN
    send_byte(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12, 0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    wait_result();
    n_tests++;
    if (got_wr.size() != w0 + 1 || got_wr[w0] !== exp_wr[0]) begin
      n_fail++;
      $display("FAIL single_write: %0d writes first=%h, required 1 write %h",
               got_wr.size() - w0, (got_wr.size() > w0) ? got_wr[w0] : '0, exp_wr[0]);
    end
    n_tests++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL single_status: done=%0d err=%0d hold=%b, required 1 0 0",
               done_cnt - d0, err_cnt - e0, core_hold);
    end
  endtask

  task automatic test_multi();
    int unsigned w0, d0;
    w0 = got_wr.size(); d0 = done_cnt;
    fill_payload(3, 1'b1);
    exp_wr.delete();
    add_expected();
    send_frame(8'h02, 0);
    wait_result();
    n_tests++;
    if (got_wr.size() - w0 != 3) begin
      n_fail++;
      $display("FAIL multi_count: %0d writes, required 3", got_wr.size() - w0);
    end
    foreach (exp_wr[i]) begin
      n_tests++;
      if (w0 + i >= got_wr.size() || got_wr[w0+i] !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL multi_wr%0d: got %h, required %h", i,
                 (w0 + i < got_wr.size()) ? got_wr[w0+i] : '0, exp_wr[i]);
      end
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL multi_done: %0d done pulses, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_garbage();
    int unsigned w0, d0, e0;
    w0 = got_wr.size(); d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h55, 1);
    send_byte(8'hAA, 1);
    fill_payload(1, 1'b0);
    exp_wr.delete();
    add_expected();
    send_frame(8'h00, 1);
    wait_result();
    n_tests++;
    if (got_wr.size() != w0 + 1 || got_wr[w0] !== exp_wr[0]) begin
      n_fail++;
      $display("FAIL garbage_write: %0d writes first=%h, required 1 write %h",
               got_wr.size() - w0, (got_wr.size() > w0) ? got_wr[w0] : '0, exp_wr[0]);
    end
    n_tests++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_fail++;
      $display("FAIL garbage_status: done=%0d err=%0d, required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_magic_in_data();
    int unsigned w0;
    w0 = got_wr.size();
    payload = '{MAGIC, MAGIC, MAGIC, MAGIC};
    send_frame(8'h00, 0);
    wait_result();
    n_tests++;
    if (got_wr.size() != w0 + 1 || got_wr[w0] !== {ADDR_W'(0), 32'hCACACACA}) begin
      n_fail++;
      $display("FAIL magic_data: %0d writes first=%h, required 1 write %h",
               got_wr.size() - w0, (got_wr.size() > w0) ? got_wr[w0] : '0, {ADDR_W'(0), 32'hCACACACA});
    end
  endtask

  task automatic test_oversize();
    int unsigned w0, d0, e0;
    w0 = got_wr.size(); d0 = done_cnt; e0 = err_cnt;
    send_byte(MAGIC, 0);
    send_byte(8'h80, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result();
    n_tests++;
    if (got_wr.size() != w0 || err_cnt - e0 != 1 || done_cnt - d0 != 0 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize: writes=%0d err=%0d done=%0d hold=%b, required 0 1 0 0",
               got_wr.size() - w0, err_cnt - e0, done_cnt - d0, core_hold);
    end
    w0 = got_wr.size(); d0 = done_cnt;
    fill_payload(1, 1'b0);
    exp_wr.delete();
    add_expected();
    send_frame(8'h00, 0);
    wait_result();
    n_tests++;
    if (got_wr.size() != w0 + 1 || got_wr[w0] !== exp_wr[0] || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL oversize_recover: %0d writes first=%h done=%0d, required 1 write %h done 1",
               got_wr.size() - w0, (got_wr.size() > w0) ? got_wr[w0] : '0, done_cnt - d0, exp_wr[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int unsigned w0;
    w0 = got_wr.size();
    fill_payload(2, 1'b0);
    exp_wr.delete();
    add_expected();
    send_byte(MAGIC, 2);
    send_byte(8'h01, 2);
    for (int unsigned i = 0; i < 6; i++) send_byte(payload[i], 2);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error} !==
        {1'b1, 1'b0, {ADDR_W{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_values: rdy=%b we=%b addr=%h wdata=%h hold=%b done=%b err=%b, required 1 0 0 0 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, core_hold, done, error);
    end
    n_tests++;
    if (got_wr.size() != w0 + 1 || got_wr[w0] !== exp_wr[0]) begin
      n_fail++;
      $display("FAIL midreset_first_word: %0d writes first=%h, required 1 write %h",
               got_wr.size() - w0, (got_wr.size() > w0) ? got_wr[w0] : '0, exp_wr[0]);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_tests++;
    if (got_wr.size() != w0 + 1 || core_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_quiet: %0d writes hold=%b, required 1 write hold 0",
               got_wr.size() - w0, core_hold);
    end
    w0 = got_wr.size();
    fill_payload(2, 1'b0);
    exp_wr.delete();
    add_expected();
    send_frame(8'h01, 2);
    wait_result();
    foreach (exp_wr[i]) begin
      n_tests++;
      if (w0 + i >= got_wr.size() || got_wr[w0+i] !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL midreset_after_wr%0d: got %h, required %h", i,
                 (w0 + i < got_wr.size()) ? got_wr[w0+i] : '0, exp_wr[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int unsigned f = 0; f < 6; f++) begin
      int unsigned w0, d0, words;
      w0 = got_wr.size(); d0 = done_cnt;
      words = $urandom_range(16, 1);
      fill_payload(words, 1'b0);
      exp_wr.delete();
      add_expected();
      send_frame(8'(words - 1), 3);
      wait_result();
      n_tests++;
      if (got_wr.size() - w0 != words || done_cnt - d0 != 1) begin
        n_fail++;
        $display("FAIL random%0d_count: %0d writes %0d done, required %0d writes 1 done",
                 f, got_wr.size() - w0, done_cnt - d0, words);
      end
      foreach (exp_wr[i]) begin
        n_tests++;
        if (w0 + i >= got_wr.size() || got_wr[w0+i] !== exp_wr[i]) begin
          n_fail++;
          $display("FAIL random%0d_wr%0d: got %h, required %h", f, i,
                   (w0 + i < got_wr.size()) ? got_wr[w0+i] : '0, exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned w0, d0;
    w0 = got_wr.size(); d0 = done_cnt;
    exp_wr.delete();
    fill_payload(2, 1'b0);
    add_expected();
    send_frame(8'h01, 0);
    fill_payload(1, 1'b0);
    add_expected();
    send_frame(8'h00, 0);
    wait_result();
    if (done_cnt - d0 < 2) wait_result();
    n_tests++;
    if (got_wr.size() - w0 != 3 || done_cnt - d0 != 2) begin
      n_fail++;
      $display("FAIL b2b_count: %0d writes %0d done, required 3 writes 2 done",
               got_wr.size() - w0, done_cnt - d0);
    end
    foreach (exp_wr[i]) begin
      n_tests++;
      if (w0 + i >= got_wr.size() || got_wr[w0+i] !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL b2b_wr%0d: got %h, required %h", i,
                 (w0 + i < got_wr.size()) ? got_wr[w0+i] : '0, exp_wr[i]);
      end
    end
  endtask

  task automatic test_max_count();
    int unsigned w0;
    w0 = got_wr.size();
    fill_payload(128, 1'b0);
    exp_wr.delete();
    add_expected();
    send_frame(8'h7F, 0);
    wait_result();
    n_tests++;
    if (got_wr.size() - w0 != 128) begin
      n_fail++;
      $display("FAIL max_count: %0d writes, required 128", got_wr.size() - w0);
    end
    n_tests++;
    if (got_wr.size() != w0 + 128 || got_wr[w0+127] !== exp_wr[127]) begin
      n_fail++;
      $display("FAIL max_last_wr: got %h, required %h",
               (got_wr.size() >= w0 + 128) ? got_wr[w0+127] : '0, exp_wr[127]);
    end
  endtask

`ifdef CAYDE_LOADER_CSUM_EN
  task automatic test_csum();
    for (int unsigned k = 0; k < 2; k++) begin
      int unsigned w0, d0, e0;
      logic [7:0] cs;
      w0 = got_wr.size(); d0 = done_cnt; e0 = err_cnt;
      cs = (k == 0) ? 8'h04 : 8'h05;
      send_byte(MAGIC, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0); send_byte(8'h02, 0);
      send_byte(8'h03, 0); send_byte(8'h04, 0);
      send_byte(cs, 0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_result();
      n_tests++;
      if (got_wr.size() != w0 + 1 || got_wr[w0] !== {ADDR_W'(0), 32'h04030201}) begin
        n_fail++;
        $display("FAIL csum%0d_write: %0d writes first=%h, required 1 write %h", k,
                 got_wr.size() - w0, (got_wr.size() > w0) ? got_wr[w0] : '0, {ADDR_W'(0), 32'h04030201});
      end
      n_tests++;
      if (done_cnt - d0 != ((k == 0) ? 1 : 0) || err_cnt - e0 != ((k == 0) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL csum%0d_status: done=%0d err=%0d, required %0d %0d", k,
                 done_cnt - d0, err_cnt - e0, (k == 0) ? 1 : 0, (k == 0) ? 0 : 1);
      end
    end
  endtask
`endif

  task automatic test_invariants();
    n_tests++;
    if (hold_viol != 0 || overlap_viol != 0) begin
      n_fail++;
      $display("FAIL invariants: hold_low_during_activity=%0d done_overlap_we=%0d, required 0 0",
               hold_viol, overlap_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_garbage();
    test_magic_in_data();
    test_oversize();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
    test_max_count();
`ifdef CAYDE_LOADER_CSUM_EN
    test_csum();
`endif
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
